// File: rtl/aes_job_arbiter_if.sv
// Job/response bundle between two requesters, the arbiter,
// the cipher core and the response consumer.
interface aes_job_arbiter_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_text;
  logic [127:0] req0_key;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_text;
  logic [127:0] req1_key;
  logic [127:0] aes_text;
  logic [127:0] aes_key;
  logic [127:0] aes_ct;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [127:0] rsp_data;

  modport master (
    output req0_valid, req0_text, req0_key,
    input  req0_ready,
    output req1_valid, req1_text, req1_key,
    input  req1_ready,
    input  aes_text, aes_key,
    output aes_ct,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_text, req0_key,
    output req0_ready,
    input  req1_valid, req1_text, req1_key,
    output req1_ready,
    output aes_text, aes_key,
    input  aes_ct,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );
endinterface

// File: rtl/aes_job_arbiter.sv
// Two-requester arbiter for a fixed-latency AES core.
// One job in flight; alternating priority on contention.
module aes_job_arbiter #(
  parameter int LATENCY = 10
) (
  input  logic clk,
  input  logic nrst,
  aes_job_arbiter_if.slave bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [7:0] LAT = 8'(LATENCY);

  state_t       state_q, state_d;
  logic         prio_q, prio_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [127:0] text_q, text_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic         id_q, id_d;

  logic gnt;
  logic hit0;
  logic hit1;

  // Grant index: prio only matters when both requesters contend
  always_comb begin
    gnt = prio_q;
    if (!(bus.req0_valid && bus.req1_valid)) begin
      gnt = bus.req1_valid;
    end
  end

  assign hit0 = (state_q == IDLE) && bus.req0_valid && !gnt;
  assign hit1 = (state_q == IDLE) && bus.req1_valid && gnt;

  // Next-state and datapath loads
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    text_d  = text_q;
    key_d   = key_q;
    data_d  = data_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (hit0 || hit1) begin
          text_d  = hit1 ? bus.req1_text : bus.req0_text;
          key_d   = hit1 ? bus.req1_key : bus.req0_key;
          id_d    = hit1;
          prio_d  = !hit1;
          cnt_d   = LAT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end
        if (cnt_q <= 8'd1) begin
          data_d  = bus.aes_ct;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= 8'd0;
      text_q  <= '0;
      key_q   <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      text_q  <= text_d;
      key_q   <= key_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  // Readies are forced low while reset is held
  assign bus.req0_ready = hit0 && nrst;
  assign bus.req1_ready = hit1 && nrst;
  assign bus.aes_text   = text_q;
  assign bus.aes_key    = key_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = data_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter.
// Covers LATENCY=10 and LATENCY=1 builds side by side.
module tb_aes_job_arbiter;

  localparam logic [127:0] T0  = 128'h3243f6a8885a308d313a98a2e0370734;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT0 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] T1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic clk;
  logic nrst;
  logic busy_a;
  logic busy_b;

  int total;
  int bad;

  aes_job_arbiter_if ia();
  aes_job_arbiter_if ib();

  aes_job_arbiter #(.LATENCY(10)) u_a (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ia),
    .busy (busy_a)
  );

  aes_job_arbiter #(.LATENCY(1)) u_b (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ib),
    .busy (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_a(output int n);
    n = 0;
    while (!ia.rsp_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
    step();
  endtask

  int n;
  int acc;
  int ids[4];
  int eds[4];
  int seen;
  int both;

  initial begin
    total = 0;
    bad   = 0;
    nrst  = 1'b0;
    ia.req0_valid = 0; ia.req0_text = T0; ia.req0_key = K0;
    ia.req1_valid = 0; ia.req1_text = T1; ia.req1_key = K1;
    ia.aes_ct = CT0;   ia.rsp_ready = 0;
    ib.req0_valid = 0; ib.req0_text = T0; ib.req0_key = K0;
    ib.req1_valid = 0; ib.req1_text = T1; ib.req1_key = K1;
    ib.aes_ct = JNK;   ib.rsp_ready = 0;

    // reset state
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_rv", ia.rsp_valid, 0);
    chk("rst_text", ia.aes_text, 0);
    chk("rst_key", ia.aes_key, 0);
    chk("rst_data", ia.rsp_data, 0);
    chk("rst_id", ia.rsp_id, 0);
    ia.req0_valid = 1;
    ia.req1_valid = 1;
    #1;
    chk("rst_rdy0", ia.req0_ready, 0);
    chk("rst_rdy1", ia.req1_ready, 0);
    nrst = 1'b1;
    #1;

    // simultaneous: req0 first
    chk("sim_rdy0", ia.req0_ready, 1);
    chk("sim_rdy1", ia.req1_ready, 0);
    step();
    ia.req0_valid = 0;
    #1;
    chk("acc_busy", busy_a, 1);
    chk("acc_text", ia.aes_text, T0);
    chk("acc_key", ia.aes_key, K0);
    chk("acc_id", ia.rsp_id, 0);
    chk("busy_rdy1", ia.req1_ready, 0);
    wait_rsp_a(n);
    chk("lat10", n, 10);
    chk("j0_data", ia.rsp_data, CT0);
    chk("j0_id", ia.rsp_id, 0);

    // backpressure with ct changing underneath
    ia.aes_ct = JNK;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", ia.rsp_valid, 1);
      chk("bp_data", ia.rsp_data, CT0);
      chk("bp_id", ia.rsp_id, 0);
      chk("bp_busy", busy_a, 1);
      chk("bp_rdy1", ia.req1_ready, 0);
      step();
    end
    ia.rsp_ready = 1;
    step();
    ia.rsp_ready = 0;
    #1;
    chk("rel_rv", ia.rsp_valid, 0);
    chk("rel_busy", busy_a, 0);
    chk("hold_text", ia.aes_text, T0);
    chk("turn_rdy1", ia.req1_ready, 1);
    ia.aes_ct = CT1;
    step();
    ia.req1_valid = 0;
    chk("j1_text", ia.aes_text, T1);
    chk("j1_key", ia.aes_key, K1);
    wait_rsp_a(n);
    chk("j1_lat", n, 10);
    chk("j1_id", ia.rsp_id, 1);
    chk("j1_data", ia.rsp_data, CT1);
    ia.rsp_ready = 1;
    step();
    chk("j1_done", busy_a, 0);

    // fairness with rsp_ready tied high
    do_reset();
    ia.req0_valid = 1;
    ia.req1_valid = 1;
    #1;
    acc  = 0;
    n    = 0;
    both = 0;
    while (acc < 4 && n < 200) begin
      if (ia.req0_ready && ia.req1_ready) both++;
      if (ia.req0_ready || ia.req1_ready) begin
        ids[acc] = ia.req1_ready ? 1 : 0;
        eds[acc] = n;
        acc++;
        step();
        n++;
        chk("fair_text", ia.aes_text, ids[acc-1] != 0 ? T1 : T0);
      end else begin
        step();
        n++;
      end
    end
    chk("fair_cnt", acc, 4);
    chk("fair_both", both, 0);
    chk("fair_id0", ids[0], 0);
    chk("fair_id1", ids[1], 1);
    chk("fair_id2", ids[2], 0);
    chk("fair_id3", ids[3], 1);
    for (int i = 0; i < 3; i++) begin
      chk("fair_span", eds[i+1] - eds[i], 12);
    end
    ia.req0_valid = 0;
    ia.req1_valid = 0;
    ia.rsp_ready  = 0;

    // mid-job reset
    do_reset();
    ia.aes_ct = CT0;
    ia.req0_valid = 1;
    #1;
    chk("mid_rdy0", ia.req0_ready, 1);
    step();
    step();
    step();
    step();
    chk("mid_busy_pre", busy_a, 1);
    nrst = 1'b0;
    #1;
    chk("mid_busy", busy_a, 0);
    chk("mid_text", ia.aes_text, 0);
    chk("mid_key", ia.aes_key, 0);
    chk("mid_data", ia.rsp_data, 0);
    chk("mid_id", ia.rsp_id, 0);
    chk("mid_rv", ia.rsp_valid, 0);
    chk("mid_rdy0", ia.req0_ready, 0);
    ia.req0_valid = 0;
    #1;
    nrst = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (ia.rsp_valid) seen++;
    end
    chk("mid_norsp", seen, 0);
    ia.aes_ct = CT1;
    ia.req1_valid = 1;
    #1;
    chk("post_rdy1", ia.req1_ready, 1);
    step();
    ia.req1_valid = 0;
    wait_rsp_a(n);
    chk("post_lat", n, 10);
    chk("post_id", ia.rsp_id, 1);
    chk("post_data", ia.rsp_data, CT1);
    ia.rsp_ready = 1;
    step();
    ia.rsp_ready = 0;

    // LATENCY=1 build
    ib.req1_valid = 1;
    #1;
    chk("l1_rdy1", ib.req1_ready, 1);
    step();
    ib.req1_valid = 0;
    ib.aes_ct = CT1;
    chk("l1_rv0", ib.rsp_valid, 0);
    chk("l1_busy", busy_b, 1);
    step();
    ib.aes_ct = JNK;
    chk("l1_rv1", ib.rsp_valid, 1);
    chk("l1_data", ib.rsp_data, CT1);
    chk("l1_id", ib.rsp_id, 1);
    step();
    chk("l1_hold", ib.rsp_data, CT1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameter: LATENCY, default 10, clock edges from job issue to valid ciphertext at the cipher core output (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 presents a job.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 job this cycle.
REQ-006 req0_text  input  128  requester 0 plaintext.
REQ-007 req0_key  input  128  requester 0 key.
REQ-008 req1_valid / req1_ready / req1_text / req1_key  same directions and widths as REQ-004..007, for requester 1.
REQ-009 aes_text  output  128  registered plaintext driven to cipher core usrText.
REQ-010 aes_key  output  128  registered key driven to cipher core Key.
REQ-011 aes_ct  input  128  cipher core encUsrText.
REQ-012 rsp_valid  output  1  ciphertext response available.
REQ-013 rsp_ready  input  1  consumer takes response.
REQ-014 rsp_id  output  1  requester index owning the response.
REQ-015 rsp_data  output  128  captured ciphertext.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, BUSY, RESP; one job in flight at most.
REQ-018 Grant in IDLE: only req0 valid -> 0; only req1 valid -> 1; both valid -> index held in priority pointer prio.
REQ-019 reqN_ready: high only in IDLE, only for the granted index, only while that reqN_valid is high; combinational from state, prio, valids.
REQ-020 Acceptance: edge with reqN_valid && reqN_ready -> aes_text/aes_key load reqN_text/reqN_key, rsp_id loads N, counter loads LATENCY, prio loads !N, state -> BUSY.
REQ-021 aes_text/aes_key: hold stable from acceptance until next acceptance; not cleared on job completion.
REQ-022 BUSY: counter decrements each edge; on edge where counter == 1, rsp_data <= aes_ct, state -> RESP; rsp_valid first high exactly LATENCY edges after acceptance edge.
REQ-023 LATENCY == 1: capture on first edge after acceptance.
REQ-024 RESP: rsp_valid high; rsp_data, rsp_id stable; both req readies low; aes_ct ignored.
REQ-025 RESP exit: edge with rsp_ready high -> rsp_valid low, state -> IDLE; new acceptance earliest the following edge (no same-cycle turnaround).
REQ-026 rsp_ready high outside RESP: ignored.
REQ-027 Valid withdrawn in IDLE before acceptance: no state change; grant recomputed each cycle; prio unchanged.
REQ-028 Requester inputs ignored in BUSY and RESP; counter is 8 bits, never wraps (loaded only on acceptance, stops at RESP).

Reset
REQ-029 nrst low: immediately state IDLE, prio 0, counter 0, aes_text 0, aes_key 0, rsp_data 0, rsp_id 0, rsp_valid 0, busy 0, req0_ready/req1_ready 0 while nrst low.
REQ-030 Reset during BUSY or RESP: in-flight job abandoned, no response produced; after release first accepted job behaves as after power-up.

Verification
REQ-031 Single job: LATENCY=10, req0 text 3243f6a8885a308d313a98a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, real cipher core -> rsp_valid exactly 10 edges after acceptance, rsp_data 3925841d02dc09fbdc118597196a0b32, rsp_id 0.
REQ-032 Simultaneous after reset: req0 and req1 valid same cycle -> req0 accepted first (rsp_id 0), req1 accepted after first response consumed (rsp_id 1), req1_ready low until then.
REQ-033 Fairness: both requesters continuously valid, rsp_ready tied high -> acceptances alternate 0,1,0,1 over 4 jobs; each job spans LATENCY+2 edges.
REQ-034 Backpressure: rsp_ready low 5 cycles after rsp_valid rises -> rsp_valid, rsp_data, rsp_id constant, busy high, no acceptance; IDLE on edge rsp_ready goes high.
REQ-035 Mid-job reset: nrst pulsed low 3 edges after acceptance -> all outputs 0 immediately, rsp_valid never asserts for that job; next req1 job completes normally with rsp_id 1.
REQ-036 LATENCY=1 build: req1 job -> rsp_valid on second edge after acceptance edge minus one, i.e. one edge after acceptance, rsp_data equals aes_ct sampled at that edge.
